prog_loader: RTL and testbench
==============================

# prog_loader

Program loader that encodes instruction fields into 8-bit instruction words and writes them sequentially into the instruction memory of the 4-stage pipelined processor. It is the encoding counterpart of the control decoder: it produces the opcode/field layout that the decoder consumes. It sits between the bench or host interface and the instruction-memory write port, and holds the CPU stalled while a program is being loaded.

## Interface
- ADDR_W, 4, instruction-memory address width (2^ADDR_W slots)
- FIFO_DEPTH, 4, encoded-word buffer depth (power of two, ≥2)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a load session
- in_valid  in  1  instruction fields valid
- in_ready  out  1  loader accepts fields this cycle
- in_last  in  1  qualifies final instruction of the program
- op  in  2  opcode: 00 MOVI, 01 SLL, 11 JMP, 10 illegal
- rd  in  3  destination register
- rs  in  3  source register (SLL)
- imm  in  6  immediate (MOVI uses [2:0]; JMP uses [5:0])
- imem_we  out  1  instruction-memory write enable
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  8  encoded instruction
- cpu_hold  out  1  keeps processor stalled while loading
- done  out  1  one-cycle pulse at end of session
- prog_len  out  ADDR_W+1  words written in last session
- err_illegal  out  1  sticky: illegal opcode seen this session
- err_overflow  out  1  sticky: more than 2^ADDR_W words offered

## Operation
- Encoding: MOVI = {2'b00, rd, imm[2:0]}; SLL = {2'b01, rd, rs}; JMP = {2'b11, imm[5:0]}.
- FSM states: IDLE, LOAD, DRAIN, FINISH.
- IDLE: in_ready=0, cpu_hold=0. start → LOAD; clears write pointer, prog_len, both error flags.
- LOAD: cpu_hold=1; in_ready = FIFO not full. Handshake = in_valid && in_ready. Accepted legal op is encoded and pushed; op=10 is dropped (not pushed, not counted) and sets err_illegal. Handshake with in_last=1 → DRAIN (applies even if that op is illegal).
- FIFO pops one word per cycle whenever non-empty (LOAD or DRAIN); pop drives a registered write to imem at current address, then address increments.
- Overflow: once 2^ADDR_W words written, further pops are discarded (no imem_we), err_overflow set; address never wraps.
- DRAIN: in_ready=0, cpu_hold=1; when FIFO empty and no write in flight → FINISH.
- FINISH: done=1 for exactly one cycle, cpu_hold drops in the same cycle, → IDLE. prog_len holds until next start.
- start outside IDLE is ignored. Push and pop in the same cycle are allowed.

## Timing
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=0, done=0, prog_len=0, err flags=0; FSM=IDLE, FIFO empty.
- start at edge k → LOAD after k; in_ready may be 1 in cycle k+1.
- Latency: handshake at edge k with FIFO empty → imem_we=1 during cycle after edge k+1 (2 cycles). Sustained throughput 1 word/cycle.
- in_last accepted at edge k with FIFO empty → final imem_we after k+1, FINISH/done after k+2.
- Reset asserted mid-session: next cycle all outputs at reset values, FIFO flushed, no further imem writes.

## Structure
- Shared package: opcode constants OP_MOVI=2'b00, OP_SLL=2'b01, OP_JMP=2'b11, field positions (opcode [7:6], rd [5:3], rs/imm3 [2:0], imm6 [5:0]), state enum. Same constants used by the control decoder.
- One sub-module: sync_fifo (parameterised width/depth, full/empty, synchronous reset).

## Test plan
- start; MOVI rd=2 imm=5, SLL rd=2 rs=1, JMP imm=6'h3E (last) → writes 0x15@0, 0x51@1, 0xFE@2; done once; prog_len=3; cpu_hold 1→0 with done.
- Back-to-back in_valid with imem continuously accepting → in_ready stays 1, one imem_we per cycle, contiguous addresses, 2-cycle first-word latency.
- op=10 mid-stream among 3 legal ops → only 3 writes, addresses contiguous, err_illegal=1, prog_len=3.
- ADDR_W=4, 18 instructions offered → 16 writes at 0..15, no write to address 0 again, err_overflow=1, prog_len=16.
- reset asserted after 2 of 5 instructions → outputs at reset values next cycle, no further imem_we; fresh start reloads from address 0 with cleared flags.
- start pulsed while in LOAD and in_valid in IDLE → ignored; no writes, in_ready=0 in IDLE.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: instruction opcodes, field layout, loader states and encoder
package prog_loader_pkg;
  localparam logic [1:0] OP_MOVI = 2'b00;
  localparam logic [1:0] OP_SLL  = 2'b01;
  localparam logic [1:0] OP_ILL  = 2'b10;
  localparam logic [1:0] OP_JMP  = 2'b11;
  localparam int OPC_HI  = 7;
  localparam int OPC_LO  = 6;
  localparam int RD_HI   = 5;
  localparam int RD_LO   = 3;
  localparam int RS_HI   = 2;
  localparam int RS_LO   = 0;
  localparam int IMM6_HI = 5;
  localparam int IMM6_LO = 0;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;
  function automatic logic [7:0] encode(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [5:0] imm);
    logic [7:0] w;
    w = '0;
    w[OPC_HI:OPC_LO] = op;
    if (op == OP_JMP) w[IMM6_HI:IMM6_LO] = imm;
    else begin
      w[RD_HI:RD_LO] = rd;
      w[RS_HI:RS_LO] = (op == OP_SLL) ? rs : imm[2:0];
    end
    return w;
  endfunction
endpackage

// File: rtl/prog_loader_sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty flags and synchronous reset
module sync_fifo #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int A = $clog2(D);
  logic [W-1:0] mem [D];
  logic [A-1:0] wp, rp;
  logic [A:0]   n;
  logic         pw, pr;
  assign full  = n == (A+1)'(D);
  assign empty = n == '0;
  assign dout  = mem[rp];
  assign pw    = push && !full;
  assign pr    = pop && !empty;
  // storage array, not reset: only entries between rp and wp are ever read
  always_ff @(posedge clk)
    if (pw) mem[wp] <= din;
  // pointers and occupancy
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      n  <= '0;
    end else begin
      if (pw) wp <= wp + 1'b1;
      if (pr) rp <= rp + 1'b1;
      n <= n + {{A{1'b0}}, pw} - {{A{1'b0}}, pr};
    end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: encodes instruction fields and streams them into instruction memory
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        op,
  input  logic [2:0]        rd,
  input  logic [2:0]        rs,
  input  logic [5:0]        imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic [ADDR_W:0]   prog_len,
  output logic              err_illegal,
  output logic              err_overflow
);
  localparam logic [ADDR_W:0] SLOTS = {1'b1, {ADDR_W{1'b0}}};
  logic [1:0]      state, nxt;
  logic [ADDR_W:0] cnt;
  logic            hs, push, pop, wr, full, empty;
  logic [7:0]      fdout;
  assign in_ready = state == S_LOAD && !full;
  assign hs       = in_valid && in_ready;
  assign push     = hs && op != OP_ILL;
  assign pop      = !empty;
  assign wr       = pop && cnt != SLOTS;
  assign cpu_hold = state == S_LOAD || state == S_DRAIN;
  assign done     = state == S_FINISH;
  assign prog_len = cnt;
  sync_fifo #(.W(8), .D(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(reset), .push(push), .din(encode(op, rd, rs, imm)),
    .pop(pop), .dout(fdout), .full(full), .empty(empty)
  );
  // session sequencing; DRAIN exits once the last word has been popped
  always_comb
    nxt = state == S_IDLE  ? (start ? S_LOAD : S_IDLE) :
          state == S_LOAD  ? (hs && in_last ? S_DRAIN : S_LOAD) :
          state == S_DRAIN ? (empty ? S_FINISH : S_DRAIN) : S_IDLE;
  // state, registered imem write port, word count and sticky errors
  always_ff @(posedge clk)
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      err_illegal  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state   <= nxt;
      imem_we <= wr;
      if (wr) begin
        imem_addr  <= cnt[ADDR_W-1:0];
        imem_wdata <= fdout;
        cnt        <= cnt + 1'b1;
      end
      if (pop && !wr) err_overflow <= 1'b1;
      if (hs && op == OP_ILL) err_illegal <= 1'b1;
      if (state == S_IDLE && start) begin
        cnt          <= '0;
        err_illegal  <= 1'b0;
        err_overflow <= 1'b0;
      end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed stimulus with a scoreboard of expected imem writes
module tb_prog_loader;
  logic clk = 0, reset = 1, start = 0, in_valid = 0, in_last = 0;
  logic [1:0] op = 0;
  logic [2:0] rd = 0, rs = 0;
  logic [5:0] imm = 0;
  logic in_ready, imem_we, cpu_hold, done, err_illegal, err_overflow;
  logic [3:0] imem_addr;
  logic [7:0] imem_wdata;
  logic [4:0] prog_len;
  int tests = 0, fails = 0, cyc = 0;
  int qa[$], qd[$];
  int exp_addr, first_hs, first_we, last_hs, done_cyc, done_cnt = 0, stalls;
  logic prev_hold = 0;

  prog_loader #(.ADDR_W(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .op(op), .rd(rd), .rs(rs), .imm(imm), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done),
    .prog_len(prog_len), .err_illegal(err_illegal), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: every imem write must match the head of the scoreboard
  always @(negedge clk) begin
    if (imem_we) begin
      if (qa.size() == 0) chk("unexpected_write_addr", int'(imem_addr), -1);
      else begin
        chk("write_addr", int'(imem_addr), qa.pop_front());
        chk("write_data", int'(imem_wdata), qd.pop_front());
      end
      if (first_we < 0) first_we = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("hold_drop_at_done", {prev_hold, cpu_hold}, 2'b10);
    end
    prev_hold = cpu_hold;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic begin_session();
    qa.delete(); qd.delete();
    exp_addr = 0; first_hs = -1; first_we = -1; stalls = 0;
    start = 1; tick(); start = 0;
  endtask

  task automatic send(input logic [1:0] o, input logic [2:0] d, input logic [2:0] s,
                      input logic [5:0] i, input logic l, input int expw);
    int t;
    op = o; rd = d; rs = s; imm = i; in_last = l; in_valid = 1; t = 0;
    while (!in_ready && t < 50) begin tick(); t++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    stalls += t;
    tick();
    last_hs = cyc;
    if (first_hs < 0) first_hs = cyc;
    if (o != 2'b10 && exp_addr < 16) begin qa.push_back(exp_addr); qd.push_back(expw); exp_addr++; end
  endtask

  task automatic end_session(input string name, input int len, input int ill, input int ovf);
    int t, d0;
    in_valid = 0; in_last = 0; d0 = done_cnt; t = 0;
    while (done_cnt == d0 && t < 100) begin tick(); t++; end
    tick(3);
    chk({name, "_done_once"}, done_cnt - d0, 1);
    chk({name, "_all_written"}, qa.size(), 0);
    chk({name, "_prog_len"}, int'(prog_len), len);
    chk({name, "_err_illegal"}, int'(err_illegal), ill);
    chk({name, "_err_overflow"}, int'(err_overflow), ovf);
    chk({name, "_hold_idle"}, int'(cpu_hold), 0);
  endtask

  initial begin
    tick(3);
    chk("rst_outputs", {in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, prog_len, err_illegal, err_overflow}, 0);
    reset = 0; tick(2);
    // basic three-instruction program
    begin_session();
    send(2'b00, 3'd2, 3'd0, 6'd5, 0, 8'h15);
    send(2'b01, 3'd2, 3'd1, 6'd0, 0, 8'h51);
    send(2'b11, 3'd0, 3'd0, 6'h3E, 1, 8'hFE);
    end_session("basic", 3, 0, 0);
    chk("basic_latency", first_we - first_hs, 1);
    chk("basic_done_latency", done_cyc - last_hs, 2);
    // back-to-back stream
    begin_session();
    send(2'b00, 3'd1, 3'd0, 6'd7, 0, 8'h0F);
    send(2'b01, 3'd7, 3'd3, 6'd0, 0, 8'h7B);
    send(2'b11, 3'd0, 3'd0, 6'h01, 0, 8'hC1);
    send(2'b00, 3'd5, 3'd0, 6'h3A, 0, 8'h2A);
    send(2'b01, 3'd0, 3'd6, 6'd0, 0, 8'h46);
    send(2'b11, 3'd0, 3'd0, 6'h2D, 1, 8'hED);
    chk("b2b_no_stall", stalls, 0);
    end_session("b2b", 6, 0, 0);
    chk("b2b_latency", first_we - first_hs, 1);
    // illegal opcode mid-stream
    begin_session();
    send(2'b00, 3'd3, 3'd0, 6'd1, 0, 8'h19);
    send(2'b10, 3'd3, 3'd3, 6'd3, 0, 0);
    send(2'b01, 3'd4, 3'd2, 6'd0, 0, 8'h62);
    send(2'b11, 3'd0, 3'd0, 6'h00, 1, 8'hC0);
    end_session("illegal", 3, 1, 0);
    // overflow: 18 offered, 16 slots
    begin_session();
    for (int i = 0; i < 18; i++) send(2'b11, 3'd0, 3'd0, 6'(i), i == 17, 8'hC0 + i);
    end_session("overflow", 16, 0, 1);
    // reset mid-session after two of five
    begin_session();
    send(2'b00, 3'd1, 3'd0, 6'd1, 0, 8'h09);
    send(2'b00, 3'd2, 3'd0, 6'd2, 0, 8'h12);
    in_valid = 0; reset = 1; tick();
    qa.delete(); qd.delete();
    chk("midrst_outputs", {in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, prog_len, err_illegal, err_overflow}, 0);
    reset = 0; tick(5);
    chk("midrst_idle_len", int'(prog_len), 0);
    begin_session();
    send(2'b01, 3'd1, 3'd1, 6'd0, 0, 8'h49);
    send(2'b11, 3'd0, 3'd0, 6'h15, 1, 8'hD5);
    end_session("reload", 2, 0, 0);
    // in_valid in IDLE and start during LOAD are ignored
    op = 2'b00; in_valid = 1; tick();
    chk("idle_in_ready", int'(in_ready), 0);
    tick(3);
    chk("idle_no_hold", int'(cpu_hold), 0);
    in_valid = 0;
    begin_session();
    send(2'b00, 3'd6, 3'd0, 6'd4, 0, 8'h34);
    in_valid = 0; start = 1; tick(); start = 0; tick(3);
    chk("restart_ignored_hold", int'(cpu_hold), 1);
    send(2'b01, 3'd6, 3'd5, 6'd0, 1, 8'h75);
    end_session("restart", 2, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
